// File: rtl/mem_bist_if.sv
// Single-port memory bus between the BIST sequencer (master) and the memory (slave).
// data is a shared tristate net: the master drives it while writing, the memory while reading.
interface mem_bist_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic              wr;
  logic              rd;
  logic [AWIDTH-1:0] addr;
  wire  [DWIDTH-1:0] data;

  modport master (output wr, output rd, output addr, inout data);
  modport slave  (input wr, input rd, input addr, inout data);
endinterface

// File: rtl/mem_bist_ctrl.sv
// March-style memory BIST: write address-derived pattern, read back, repeat inverted.
// Reports pass/fail with the first failing address and data; owns the bus while busy.
module mem_bist_ctrl #(
  parameter int                AWIDTH = 5,
  parameter int                DWIDTH = 8,
  parameter logic [DWIDTH-1:0] SEED   = DWIDTH'(8'hA5)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [AWIDTH-1:0] fail_addr,
  output logic [DWIDTH-1:0] fail_data,
  mem_bist_if.master        bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [AWIDTH-1:0] LAST = '1;

  state_t            state;
  logic [AWIDTH-1:0] cnt;
  logic              phase;
  logic              err;
  logic              wr_q;
  logic              rd_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              mismatch;

  function automatic logic [DWIDTH-1:0] pat(input logic [AWIDTH-1:0] a, input logic ph);
    logic [DWIDTH-1:0] p;
    p = DWIDTH'(a) ^ SEED;
    return ph ? ~p : p;
  endfunction

  // Case inequality so an undriven or unknown read counts as a failure.
  assign mismatch = (bus.data !== pat(cnt, phase));

  assign bus.wr   = wr_q;
  assign bus.rd   = rd_q;
  assign bus.addr = cnt;
  assign bus.data = wr_q ? wdata_q : {DWIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      phase     <= 1'b0;
      err       <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= WRITE;
            cnt       <= '0;
            phase     <= 1'b0;
            err       <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            wr_q      <= 1'b1;
            rd_q      <= 1'b0;
            wdata_q   <= pat('0, 1'b0);
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        WRITE: begin
          if (cnt == LAST) begin
            state <= READ;
            cnt   <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b1;
          end else begin
            cnt     <= cnt + 1'b1;
            wdata_q <= pat(cnt + 1'b1, phase);
          end
        end
        READ: begin
          if (mismatch && !err) begin
            err       <= 1'b1;
            fail_addr <= cnt;
            fail_data <= bus.data;
          end
          if (cnt == LAST) begin
            cnt <= '0;
            if (!phase) begin
              state   <= WRITE;
              phase   <= 1'b1;
              wr_q    <= 1'b1;
              rd_q    <= 1'b0;
              wdata_q <= pat('0, 1'b1);
            end else begin
              // The last read's compare lands on the same edge as the verdict.
              state <= DONE;
              rd_q  <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= ~(err | mismatch);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: behavioural memory with injectable stuck-at faults,
// directed scenarios feeding a scoreboard, and a per-cycle bus monitor.
module tb_mem_bist_ctrl;
  localparam int          AW    = 5;
  localparam int          DW    = 8;
  localparam int          DEPTH = 32;
  localparam logic [7:0]  SEED  = 8'hA5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  mem_bist_if #(.AWIDTH(AW), .DWIDTH(DW)) mif ();

  mem_bist_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .SEED(SEED)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .bus       (mif)
  );

  always #5 clk = ~clk;

  // Behavioural memory: stuck-at faults applied on the read path.
  logic [DW-1:0] mem   [DEPTH];
  logic [DW-1:0] and_m [DEPTH];
  logic [DW-1:0] or_m  [DEPTH];

  always @(posedge clk)
    if (mif.wr) mem[mif.addr] <= mif.data;

  assign mif.data = mif.rd ? ((mem[mif.addr] & and_m[mif.addr]) | or_m[mif.addr]) : {DW{1'bz}};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] pat(input int a, input bit ph);
    logic [7:0] p;
    p = a[7:0] ^ SEED;
    return ph ? ~p : p;
  endfunction

  typedef struct {
    logic pass;
    int   fa;
    int   fd;
    int   cyc;
  } exp_t;

  exp_t sb[$];

  // Monitor: checks the bus sequence every busy cycle and scores each verdict.
  int seq = 0;
  bit prev_done = 1'b0;

  always @(negedge clk) begin
    int   k, a;
    bit   ph, ewr;
    exp_t e;
    check("excl_wr_rd", mif.wr && mif.rd, 0);
    if (busy) begin
      ph  = (seq >= 2*DEPTH);
      k   = seq % (2*DEPTH);
      a   = k % DEPTH;
      ewr = (k < DEPTH);
      check("bus_ctl", {mif.wr, mif.rd, mif.addr}, {ewr, !ewr, a[AW-1:0]});
      if (ewr && mif.wr) check("wdata", mif.data, pat(a, ph));
      seq++;
    end else begin
      if (done && !prev_done) begin
        if (sb.size() == 0) check("unexpected_done", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("pass",        pass,      e.pass);
          check("fail_addr",   fail_addr, e.fa);
          check("fail_data",   fail_data, e.fd);
          check("busy_cycles", seq,       e.cyc);
        end
      end
      seq = 0;
    end
    prev_done = done;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_test(input exp_t e);
    sb.push_back(e);
    pulse_start();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    @(negedge clk);
  endtask

  task automatic clear_faults();
    for (int i = 0; i < DEPTH; i++) begin
      and_m[i] = '1;
      or_m[i]  = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_faults();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",      busy,      0);
    check("rst_done",      done,      0);
    check("rst_pass",      pass,      0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_fail_data", fail_data, 0);
    check("rst_wr_rd",     {mif.wr, mif.rd}, 0);
    check("rst_addr",      mif.addr,  0);
    reset = 1'b0;
    @(negedge clk);

    // Fault-free run
    run_test('{1'b1, 0, 0, 128});
    wait_done();
    repeat (3) @(negedge clk);
    check("done_held", {done, pass}, 2'b11);

    // Bit0 of addr 5 stuck at 0: only the inverted pass sees it (5F read as 5E)
    and_m[5] = 8'hFE;
    run_test('{1'b0, 5, 8'h5E, 128});
    wait_done();

    // Bit7 stuck at 1 at addr 3 and 20: first failure is addr 3, 59 read as D9
    clear_faults();
    or_m[3]  = 8'h80;
    or_m[20] = 8'h80;
    run_test('{1'b0, 3, 8'hD9, 128});
    wait_done();

    // start re-pulsed mid-run is ignored
    clear_faults();
    run_test('{1'b1, 0, 0, 128});
    repeat (10) @(negedge clk);
    pulse_start();
    wait_done();

    // Reset mid-run (phase 0 read) aborts cleanly
    pulse_start();
    repeat (39) @(negedge clk);
    check("pre_rst_rd", mif.rd, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_wr_rd", {mif.wr, mif.rd}, 0);
    check("midrst_busy",  busy, 0);
    check("midrst_done",  done, 0);
    check("midrst_addr",  mif.addr, 0);
    reset = 1'b0;
    @(negedge clk);
    run_test('{1'b1, 0, 0, 128});
    wait_done();

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
